// File: rtl/io_port_pkg.sv
// Shared definitions for the IO port bank: bus width and register addresses.
package io_port_pkg;

    localparam int BUS_W = 32;

    localparam logic [1:0] ADDR_SW_STATE = 2'd0;
    localparam logic [1:0] ADDR_LED      = 2'd1;
    localparam logic [1:0] ADDR_CHANGE   = 2'd2;
    localparam logic [1:0] ADDR_IRQ_EN   = 2'd3;

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: multi-flop synchroniser followed by a persistence-count debouncer.
module switch_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o,
    output logic toggle_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sync_s;
    logic                   load_s;

    // Shift the synchroniser, count while the synced level disagrees, load on terminal count.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
        sync_s   = sync_q[SYNC_STAGES-1];
        stable_d = stable_q;
        cnt_d    = '0;
        load_s   = 1'b0;
        if (sync_s != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                load_s   = 1'b1;
                stable_d = sync_s;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // toggle_o marks the edge on which stable_o is about to flip.
    assign stable_o = stable_q;
    assign toggle_o = load_s;

endmodule

// File: rtl/io_port_bank.sv
// Debounced switch inputs, LED outputs and change-interrupt logic behind a small register bus.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SW_WIDTH-1:0]  switches,
    output logic [LED_WIDTH-1:0] led,
    input  logic [1:0]           bus_addr,
    input  logic                 bus_wr_en,
    input  logic [BUS_W-1:0]     bus_wdata,
    input  logic                 bus_rd_en,
    output logic [BUS_W-1:0]     bus_rdata,
    output logic                 bus_rdata_valid,
    output logic                 irq
);

    logic [SW_WIDTH-1:0]  sw_stable_s;
    logic [SW_WIDTH-1:0]  sw_toggle_s;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [SW_WIDTH-1:0]  change_q, change_d;
    logic [SW_WIDTH-1:0]  irq_en_q, irq_en_d;
    logic [BUS_W-1:0]     rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 irq_q, irq_d;
    logic                 unused_wdata_s;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        switch_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (switches[i]),
            .stable_o (sw_stable_s[i]),
            .toggle_o (sw_toggle_s[i])
        );
    end

    // Register writes, change capture (set beats clear) and the read-data pipeline.
    always_comb begin
        led_d    = led_q;
        irq_en_d = irq_en_q;
        change_d = change_q;
        rdata_d  = '0;
        rvalid_d = 1'b0;

        if (bus_wr_en) begin
            case (bus_addr)
                ADDR_LED:    led_d    = bus_wdata[LED_WIDTH-1:0];
                ADDR_CHANGE: change_d = change_q & ~bus_wdata[SW_WIDTH-1:0];
                ADDR_IRQ_EN: irq_en_d = bus_wdata[SW_WIDTH-1:0];
                default:     led_d    = led_q;
            endcase
        end else begin
            led_d = led_q;
        end
        change_d = change_d | sw_toggle_s;

        // Reads sample the pre-edge register values, so a same-cycle write or set is not visible.
        if (bus_rd_en) begin
            rvalid_d = 1'b1;
            case (bus_addr)
                ADDR_SW_STATE: rdata_d[SW_WIDTH-1:0]  = sw_stable_s;
                ADDR_LED:      rdata_d[LED_WIDTH-1:0] = led_q;
                ADDR_CHANGE:   rdata_d[SW_WIDTH-1:0]  = change_q;
                ADDR_IRQ_EN:   rdata_d[SW_WIDTH-1:0]  = irq_en_q;
                default:       rdata_d = '0;
            endcase
        end else begin
            rvalid_d = 1'b0;
        end

        irq_d = |(change_q & irq_en_q);
    end

    // Register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q    <= '0;
            change_q <= '0;
            irq_en_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            led_q    <= led_d;
            change_q <= change_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign unused_wdata_s  = ^bus_wdata;
    assign led             = led_q;
    assign bus_rdata       = rdata_q;
    assign bus_rdata_valid = rvalid_q;
    assign irq             = irq_q;

endmodule
